store_xlate_queue: RTL and testbench

Parametrised store front-end that sits between the issue stage and the store buffer. It accepts stores into a DEPTH-entry in-order queue, so issue no longer stalls on a DTLB miss or a full store buffer. It translates the queue head through the DTLB port and forwards translated stores to the store buffer. It writes back each store's transaction ID, with any exception, to the scoreboard.

---
 rtl/ariane_pkg.sv | 23 ++
 rtl/store_xq_fifo.sv | 62 ++++++
 rtl/store_xlate_queue.sv | 162 ++++++++++++++++
 tb/tb_store_xlate_queue.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Shared store-queue definitions.
//   st_xq_entry_t : one queued store (virtual address, data, byte enables,
//                   transfer size, scoreboard transaction ID)
//   st_xq_ptr_w() : queue pointer width, one wrap bit above the index bits
package ariane_pkg;

    localparam int unsigned XQ_XLEN       = 64;
    localparam int unsigned XQ_VLEN       = 64;
    localparam int unsigned XQ_TRANS_ID_W = 3;

    typedef struct packed {
        logic [XQ_VLEN-1:0]       vaddr;
        logic [XQ_XLEN-1:0]       data;
        logic [XQ_XLEN/8-1:0]     be;
        logic [1:0]               size;
        logic [XQ_TRANS_ID_W-1:0] trans_id;
    } st_xq_entry_t;

    function automatic int unsigned st_xq_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/store_xq_fifo.sv
// In-order circular buffer of queued stores.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   i_flush       : synchronous clear of both pointers
//   i_push/i_entry: write one entry at the tail (caller guarantees !o_full)
//   i_pop         : retire the head entry (caller guarantees !o_empty)
//   o_head        : current head entry
//   o_full/o_empty/o_count : occupancy, decoded from the registered pointers
module store_xq_fifo
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = st_xq_ptr_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_flush,
    input  logic             i_push,
    input  st_xq_entry_t     i_entry,
    input  logic             i_pop,
    output st_xq_entry_t     o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W-1:0] o_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    st_xq_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] w_diff;

    // Storage is reset too, so the head-derived outputs read as zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr[IDX_W-1:0]] <= i_entry;
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // The wrap bit makes the pointer difference an exact occupancy count.
    assign w_diff  = r_wptr - r_rptr;
    assign o_count = w_diff;
    assign o_full  = (w_diff == PTR_W'(DEPTH));
    assign o_empty = (r_wptr == r_rptr);
    assign o_head  = r_mem[r_rptr[IDX_W-1:0]];

endmodule

// File: rtl/store_xlate_queue.sv
// Store front-end: queues stores from issue, translates the queue head
// through the DTLB, forwards translated stores to the store buffer and
// writes each store's ID (with any exception) back to the scoreboard.
//   flush_i                : drop all queued and in-flight stores
//   valid_i/ready_o        : enqueue handshake (vaddr/data/be/size/trans_id)
//   translation_req_o/...  : same-cycle DTLB lookup of the head
//   sb_valid_o/sb_ready_i  : store buffer handshake and payload
//   wb_*                   : one-cycle writeback strobe and payload
//   empty_o, count_o       : occupancy status
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high; while valid is high and ready low the payload is held unchanged.
module store_xlate_queue
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned XLEN       = XQ_XLEN,
    parameter int unsigned VLEN       = XQ_VLEN,
    parameter int unsigned PLEN       = 56,
    parameter int unsigned TRANS_ID_W = XQ_TRANS_ID_W,
    localparam int unsigned PTR_W     = st_xq_ptr_w(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [VLEN-1:0]       vaddr_i,
    input  logic [XLEN-1:0]       data_i,
    input  logic [XLEN/8-1:0]     be_i,
    input  logic [1:0]            size_i,
    input  logic [TRANS_ID_W-1:0] trans_id_i,
    output logic                  translation_req_o,
    output logic [VLEN-1:0]       vaddr_o,
    input  logic                  dtlb_hit_i,
    input  logic [PLEN-1:0]       paddr_i,
    input  logic                  ex_valid_i,
    input  logic [XLEN-1:0]       ex_cause_i,
    input  logic [XLEN-1:0]       ex_tval_i,
    output logic                  sb_valid_o,
    input  logic                  sb_ready_i,
    output logic [PLEN-1:0]       sb_paddr_o,
    output logic [XLEN-1:0]       sb_data_o,
    output logic [XLEN/8-1:0]     sb_be_o,
    output logic [1:0]            sb_size_o,
    output logic                  wb_valid_o,
    output logic [TRANS_ID_W-1:0] wb_trans_id_o,
    output logic                  wb_ex_valid_o,
    output logic [XLEN-1:0]       wb_ex_cause_o,
    output logic [XLEN-1:0]       wb_ex_tval_o,
    output logic                  empty_o,
    output logic [PTR_W-1:0]      count_o
);

    localparam logic [0:0] XLATE = 1'b0;
    localparam logic [0:0] PUSH  = 1'b1;

    logic [0:0]            r_state;
    logic [PLEN-1:0]       r_paddr;
    logic                  r_wb_valid;
    logic [TRANS_ID_W-1:0] r_wb_trans_id;
    logic                  r_wb_ex_valid;
    logic [XLEN-1:0]       r_wb_ex_cause;
    logic [XLEN-1:0]       r_wb_ex_tval;

    st_xq_entry_t w_in_entry;
    st_xq_entry_t w_head;
    logic         w_full;
    logic         w_empty;
    logic         w_push;
    logic         w_req;
    logic         w_sb_valid;
    logic         w_hit;
    logic         w_ex_pop;
    logic         w_sb_pop;
    logic         w_pop;

    always_comb begin
        w_in_entry          = '0;
        w_in_entry.vaddr    = vaddr_i;
        w_in_entry.data     = data_i;
        w_in_entry.be       = be_i;
        w_in_entry.size     = size_i;
        w_in_entry.trans_id = trans_id_i;
    end

    // Flush gates both head requests in the same cycle so nothing leaves.
    assign w_push     = valid_i && ready_o && !flush_i;
    assign w_req      = (r_state == XLATE) && !w_empty && !flush_i;
    assign w_sb_valid = (r_state == PUSH) && !flush_i;
    // An exception wins over a hit: the store is retired without a push.
    assign w_ex_pop   = w_req && ex_valid_i;
    assign w_hit      = w_req && dtlb_hit_i && !ex_valid_i;
    assign w_sb_pop   = w_sb_valid && sb_ready_i;
    assign w_pop      = w_ex_pop || w_sb_pop;

    store_xq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_flush(flush_i),
        .i_push (w_push),
        .i_entry(w_in_entry),
        .i_pop  (w_pop),
        .o_head (w_head),
        .o_full (w_full),
        .o_empty(w_empty),
        .o_count(count_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= XLATE;
            r_paddr <= '0;
        end else if (flush_i) begin
            r_state <= XLATE;
        end else if (w_hit) begin
            r_state <= PUSH;
            r_paddr <= paddr_i;
        end else if (w_sb_pop) begin
            r_state <= XLATE;
        end
    end

    // One pop per cycle at most, so a single writeback slot never overflows.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wb_valid    <= 1'b0;
            r_wb_trans_id <= '0;
            r_wb_ex_valid <= 1'b0;
            r_wb_ex_cause <= '0;
            r_wb_ex_tval  <= '0;
        end else if (flush_i) begin
            r_wb_valid <= 1'b0;
        end else begin
            r_wb_valid <= w_pop;
            if (w_pop) begin
                r_wb_trans_id <= w_head.trans_id;
                r_wb_ex_valid <= w_ex_pop;
                r_wb_ex_cause <= w_ex_pop ? ex_cause_i : '0;
                r_wb_ex_tval  <= w_ex_pop ? ex_tval_i  : '0;
            end
        end
    end

    // Full is decoded from registered pointers only; a same-cycle pop does not open a slot.
    assign ready_o           = !w_full;
    assign translation_req_o = w_req;
    assign vaddr_o           = w_head.vaddr;
    assign sb_valid_o        = w_sb_valid;
    assign sb_paddr_o        = r_paddr;
    assign sb_data_o         = w_head.data;
    assign sb_be_o           = w_head.be;
    assign sb_size_o         = w_head.size;
    assign wb_valid_o        = r_wb_valid;
    assign wb_trans_id_o     = r_wb_trans_id;
    assign wb_ex_valid_o     = r_wb_ex_valid;
    assign wb_ex_cause_o     = r_wb_ex_cause;
    assign wb_ex_tval_o      = r_wb_ex_tval;
    assign empty_o           = w_empty && !r_wb_valid;

endmodule

// File: tb/tb_store_xlate_queue.sv
// Bench for store_xlate_queue: cycle tables for the basic and fault paths,
// hand sequences for fill, backpressure, flush, wrap-around and reset, and
// a writeback / store-buffer scoreboard fed at enqueue time.
module tb_store_xlate_queue;

    localparam int unsigned DEPTH      = 4;
    localparam int unsigned XLEN       = 64;
    localparam int unsigned VLEN       = 64;
    localparam int unsigned PLEN       = 56;
    localparam int unsigned TRANS_ID_W = 3;
    localparam int unsigned CW         = 132;

    logic                  clk_i;
    logic                  rst_ni;
    logic                  flush_i;
    logic                  valid_i;
    logic                  ready_o;
    logic [VLEN-1:0]       vaddr_i;
    logic [XLEN-1:0]       data_i;
    logic [XLEN/8-1:0]     be_i;
    logic [1:0]            size_i;
    logic [TRANS_ID_W-1:0] trans_id_i;
    logic                  translation_req_o;
    logic [VLEN-1:0]       vaddr_o;
    logic                  dtlb_hit_i;
    logic [PLEN-1:0]       paddr_i;
    logic                  ex_valid_i;
    logic [XLEN-1:0]       ex_cause_i;
    logic [XLEN-1:0]       ex_tval_i;
    logic                  sb_valid_o;
    logic                  sb_ready_i;
    logic [PLEN-1:0]       sb_paddr_o;
    logic [XLEN-1:0]       sb_data_o;
    logic [XLEN/8-1:0]     sb_be_o;
    logic [1:0]            sb_size_o;
    logic                  wb_valid_o;
    logic [TRANS_ID_W-1:0] wb_trans_id_o;
    logic                  wb_ex_valid_o;
    logic [XLEN-1:0]       wb_ex_cause_o;
    logic [XLEN-1:0]       wb_ex_tval_o;
    logic                  empty_o;
    logic [2:0]            count_o;

    logic    tlb_on;
    int      total;
    int      bad;
    int      wb_seen;
    logic [CW-1:0] exp_wb_q[$];
    logic [CW-1:0] exp_sb_q[$];

    store_xlate_queue #(
        .DEPTH(DEPTH), .XLEN(XLEN), .VLEN(VLEN), .PLEN(PLEN), .TRANS_ID_W(TRANS_ID_W)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o), .vaddr_i(vaddr_i), .data_i(data_i),
        .be_i(be_i), .size_i(size_i), .trans_id_i(trans_id_i),
        .translation_req_o(translation_req_o), .vaddr_o(vaddr_o),
        .dtlb_hit_i(dtlb_hit_i), .paddr_i(paddr_i), .ex_valid_i(ex_valid_i),
        .ex_cause_i(ex_cause_i), .ex_tval_i(ex_tval_i),
        .sb_valid_o(sb_valid_o), .sb_ready_i(sb_ready_i), .sb_paddr_o(sb_paddr_o),
        .sb_data_o(sb_data_o), .sb_be_o(sb_be_o), .sb_size_o(sb_size_o),
        .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o),
        .wb_ex_valid_o(wb_ex_valid_o), .wb_ex_cause_o(wb_ex_cause_o),
        .wb_ex_tval_o(wb_ex_tval_o), .empty_o(empty_o), .count_o(count_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- reference functions ----------------
    function automatic logic is_fault(input logic [VLEN-1:0] va);
        return va[15:12] == 4'h2;
    endfunction
    function automatic logic [PLEN-1:0] paddr_of(input logic [VLEN-1:0] va);
        return {24'h0, 32'h8000_0000 | va[31:0]};
    endfunction
    function automatic logic [XLEN-1:0] data_of(input logic [VLEN-1:0] va);
        return {va[31:0], ~va[31:0]};
    endfunction
    function automatic logic [7:0] be_of(input logic [VLEN-1:0] va);
        return va[11:4] | 8'h01;
    endfunction

    // DTLB stub: hits whenever enabled; 0x2xxx pages fault with cause 15.
    always_comb begin
        dtlb_hit_i = tlb_on && translation_req_o;
        ex_valid_i = tlb_on && translation_req_o && is_fault(vaddr_o);
        ex_cause_i = 64'd15;
        ex_tval_i  = vaddr_o;
        paddr_i    = paddr_of(vaddr_o);
    end

    task automatic check(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_store(input logic [TRANS_ID_W-1:0] id, input logic [VLEN-1:0] va);
        valid_i    = 1'b1;
        vaddr_i    = va;
        data_i     = data_of(va);
        be_i       = be_of(va);
        size_i     = va[5:4];
        trans_id_i = id;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_empty(input string nm, input int budget);
        int n;
        n = 0;
        while (!empty_o && n < budget) begin
            next_cycle();
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s: got timeout after %0d cycles expected empty_o=1", nm, n);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (wb_valid_o) begin
                wb_seen++;
                if (exp_wb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wb_unexpected: got id %0d expected no writeback", wb_trans_id_o);
                end else begin
                    check("wb_record", {wb_trans_id_o, wb_ex_valid_o, wb_ex_cause_o, wb_ex_tval_o},
                          exp_wb_q.pop_front());
                end
            end
            if (sb_valid_o && sb_ready_i) begin
                if (exp_sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got paddr %0h expected no store", sb_paddr_o);
                end else begin
                    check("sb_record", CW'({sb_paddr_o, sb_data_o, sb_be_o, sb_size_o}),
                          exp_sb_q.pop_front());
                end
            end
            if (flush_i) begin
                exp_wb_q.delete();
                exp_sb_q.delete();
            end else if (valid_i && ready_o) begin
                if (is_fault(vaddr_i)) begin
                    exp_wb_q.push_back({trans_id_i, 1'b1, 64'd15, vaddr_i});
                end else begin
                    exp_wb_q.push_back({trans_id_i, 1'b0, 64'd0, 64'd0});
                    exp_sb_q.push_back(CW'({paddr_of(vaddr_i), data_of(vaddr_i), be_of(vaddr_i), vaddr_i[5:4]}));
                end
            end
        end
    end

    // ---------------- cycle table ----------------
    typedef struct {
        logic            v;
        logic [2:0]      id;
        logic [VLEN-1:0] vaddr;
        logic            e_ready;
        logic            e_req;
        logic [VLEN-1:0] e_vaddr;
        logic            e_sb;
        logic            e_wb;
        logic [2:0]      e_count;
        logic            e_empty;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic v, input logic [2:0] id, input logic [VLEN-1:0] va,
                                input logic rdy, input logic req, input logic [VLEN-1:0] eva,
                                input logic sb, input logic wb, input logic [2:0] cnt,
                                input logic emp);
        vec_t r;
        r.v = v; r.id = id; r.vaddr = va; r.e_ready = rdy; r.e_req = req;
        r.e_vaddr = eva; r.e_sb = sb; r.e_wb = wb; r.e_count = cnt; r.e_empty = emp;
        return r;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int cyc;
        logic [VLEN-1:0] va;
        total = 0; bad = 0; wb_seen = 0;
        rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; vaddr_i = '0; data_i = '0;
        be_i = '0; size_i = '0; trans_id_i = '0; sb_ready_i = 1'b0; tlb_on = 1'b0;

        // Single store, hit, ready: req at 1, sb at 2 (paddr 0x8000_1000), wb at 3.
        tbl[0]  = mk(1, 5, 64'h1000, 1, 0, 64'h0,    0, 0, 0, 1);
        tbl[1]  = mk(0, 0, 64'h0,    1, 1, 64'h1000, 0, 0, 1, 0);
        tbl[2]  = mk(0, 0, 64'h0,    1, 0, 64'h0,    1, 0, 1, 0);
        tbl[3]  = mk(0, 0, 64'h0,    1, 0, 64'h0,    0, 1, 0, 0);
        tbl[4]  = mk(0, 0, 64'h0,    1, 0, 64'h0,    0, 0, 0, 1);
        // Head page fault, then the next entry translates the following cycle.
        tbl[5]  = mk(1, 1, 64'h2000, 1, 0, 64'h0,    0, 0, 0, 1);
        tbl[6]  = mk(1, 2, 64'h1020, 1, 1, 64'h2000, 0, 0, 1, 0);
        tbl[7]  = mk(0, 0, 64'h0,    1, 1, 64'h1020, 0, 1, 1, 0);
        tbl[8]  = mk(0, 0, 64'h0,    1, 0, 64'h0,    1, 0, 1, 0);
        tbl[9]  = mk(0, 0, 64'h0,    1, 0, 64'h0,    0, 1, 0, 0);
        tbl[10] = mk(0, 0, 64'h0,    1, 0, 64'h0,    0, 0, 0, 1);

        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", CW'(ready_o), CW'(1'b1));
        check("rst_empty", CW'(empty_o), CW'(1'b1));
        check("rst_count", CW'(count_o), CW'(3'd0));
        check("rst_req",   CW'(translation_req_o), CW'(1'b0));
        check("rst_sb",    CW'(sb_valid_o), CW'(1'b0));
        check("rst_wb",    CW'({wb_valid_o, wb_trans_id_o, wb_ex_valid_o}), CW'(5'd0));
        check("rst_vaddr", CW'(vaddr_o), CW'(64'd0));
        rst_ni = 1'b1;
        next_cycle();

        tlb_on = 1'b1;
        sb_ready_i = 1'b1;
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].v) drive_store(tbl[i].id, tbl[i].vaddr);
            else valid_i = 1'b0;
            @(negedge clk_i);
            check($sformatf("tbl%0d_ready", i), CW'(ready_o), CW'(tbl[i].e_ready));
            check($sformatf("tbl%0d_req", i),   CW'(translation_req_o), CW'(tbl[i].e_req));
            check($sformatf("tbl%0d_sb", i),    CW'(sb_valid_o), CW'(tbl[i].e_sb));
            check($sformatf("tbl%0d_wb", i),    CW'(wb_valid_o), CW'(tbl[i].e_wb));
            check($sformatf("tbl%0d_count", i), CW'(count_o), CW'(tbl[i].e_count));
            check($sformatf("tbl%0d_empty", i), CW'(empty_o), CW'(tbl[i].e_empty));
            if (tbl[i].e_req) check($sformatf("tbl%0d_vaddr", i), CW'(vaddr_o), CW'(tbl[i].e_vaddr));
            next_cycle();
        end
        valid_i = 1'b0;

        // Fill while the DTLB misses; an extra offer while full is not taken.
        tlb_on = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_store(3'(k), 64'h1000 + 64'(k) * 64'h10);
            @(negedge clk_i);
            check($sformatf("fill%0d_ready", k), CW'(ready_o), CW'(1'b1));
            next_cycle();
        end
        drive_store(3'd7, 64'h1070);
        @(negedge clk_i);
        check("full_ready", CW'(ready_o), CW'(1'b0));
        check("full_count", CW'(count_o), CW'(3'd4));
        next_cycle();
        valid_i = 1'b0;
        tlb_on = 1'b1;
        @(negedge clk_i);
        check("full_ready_hit", CW'(ready_o), CW'(1'b0));
        next_cycle();
        @(negedge clk_i);
        check("full_ready_pop", CW'(ready_o), CW'(1'b0));
        next_cycle();
        @(negedge clk_i);
        check("ready_after_pop", CW'(ready_o), CW'(1'b1));
        next_cycle();
        wait_empty("fill_drain", 100);
        check("fill_sb_left", CW'(exp_wb_q.size()), CW'(0));

        // Store buffer backpressure for 5 cycles in PUSH.
        sb_ready_i = 1'b0;
        wb_seen = 0;
        va = 64'h1230;
        drive_store(3'd3, va);
        next_cycle();
        valid_i = 1'b0;
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check($sformatf("bp%0d_valid", k), CW'(sb_valid_o), CW'(1'b1));
            check($sformatf("bp%0d_payload", k), CW'({sb_paddr_o, sb_data_o, sb_be_o, sb_size_o}),
                  CW'({paddr_of(va), data_of(va), be_of(va), va[5:4]}));
            next_cycle();
        end
        sb_ready_i = 1'b1;
        wait_empty("bp_drain", 20);
        check("bp_wb_once", CW'(wb_seen), CW'(1));

        // Flush with three entries (head in PUSH) and an enqueue on the flush cycle.
        sb_ready_i = 1'b0;
        drive_store(3'd4, 64'h1400); next_cycle();
        drive_store(3'd5, 64'h1500); next_cycle();
        drive_store(3'd6, 64'h1600); next_cycle();
        drive_store(3'd7, 64'h1700);
        flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_sb_gated",  CW'(sb_valid_o), CW'(1'b0));
        check("flush_req_gated", CW'(translation_req_o), CW'(1'b0));
        check("flush_count_pre", CW'(count_o), CW'(3'd3));
        next_cycle();
        flush_i = 1'b0;
        valid_i = 1'b0;
        sb_ready_i = 1'b1;
        wb_seen = 0;
        @(negedge clk_i);
        check("flush_count", CW'(count_o), CW'(3'd0));
        check("flush_empty", CW'(empty_o), CW'(1'b1));
        repeat (10) next_cycle();
        check("flush_no_wb", CW'(wb_seen), CW'(0));

        // Wrap-around: 3*DEPTH stores at full rate, some faulting.
        wb_seen = 0;
        n = 0;
        cyc = 0;
        while (n < 3 * DEPTH && cyc < 200) begin
            if (ready_o) begin
                if (n % 5 == 4) drive_store(3'(n % 8), 64'h2000 + 64'(n) * 64'h10);
                else            drive_store(3'(n % 8), 64'h3000 + 64'(n) * 64'h10);
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk_i);
            if (valid_i && ready_o) n++;
            next_cycle();
            cyc++;
        end
        valid_i = 1'b0;
        check("wrap_enqueued", CW'(n), CW'(3 * DEPTH));
        wait_empty("wrap_drain", 100);
        check("wrap_wb_count", CW'(wb_seen), CW'(3 * DEPTH));
        check("wrap_sb_left", CW'(exp_sb_q.size()), CW'(0));

        // Reset mid-operation: immediate return to reset values, no writeback afterwards.
        sb_ready_i = 1'b0;
        drive_store(3'd1, 64'h1100); next_cycle();
        drive_store(3'd2, 64'h1200); next_cycle();
        valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("mrst_ready", CW'(ready_o), CW'(1'b1));
        check("mrst_empty", CW'(empty_o), CW'(1'b1));
        check("mrst_count", CW'(count_o), CW'(3'd0));
        check("mrst_out",   CW'({sb_valid_o, translation_req_o, wb_valid_o}), CW'(3'd0));
        check("mrst_paddr", CW'(sb_paddr_o), CW'(56'd0));
        exp_wb_q.delete();
        exp_sb_q.delete();
        next_cycle();
        rst_ni = 1'b1;
        sb_ready_i = 1'b1;
        wb_seen = 0;
        repeat (10) next_cycle();
        check("mrst_no_wb", CW'(wb_seen), CW'(0));
        check("mrst_idle_empty", CW'(empty_o), CW'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
